// File: rtl/pdm2pcm_sequencer_if.sv
// Control and strobe bundle between the register file / datapath and the
// PDM sequencer. The master side owns the control fields and consumes the
// PDM clock and per-channel strobes; the slave side is the sequencer.
interface pdm2pcm_sequencer_if #(
   parameter int DIV_WIDTH = 7,
   parameter int DEC_WIDTH = 8
);
   logic                 interface_enable_i;
   logic                 dual_channel_i;
   logic                 channel_i;
   logic [DIV_WIDTH-1:0] clock_divisor_i;
   logic [DEC_WIDTH-1:0] decimation_factor_i;

   logic                 pdm_clk_o;
   logic                 filter_clear_o;
   logic                 sample_left_o;
   logic                 sample_right_o;
   logic                 decimate_left_o;
   logic                 decimate_right_o;
   logic                 busy_o;

   modport master (
      output interface_enable_i, dual_channel_i, channel_i,
      output clock_divisor_i, decimation_factor_i,
      input  pdm_clk_o, filter_clear_o, sample_left_o, sample_right_o,
      input  decimate_left_o, decimate_right_o, busy_o
   );

   modport slave (
      input  interface_enable_i, dual_channel_i, channel_i,
      input  clock_divisor_i, decimation_factor_i,
      output pdm_clk_o, filter_clear_o, sample_left_o, sample_right_o,
      output decimate_left_o, decimate_right_o, busy_o
   );
endinterface

// File: rtl/pdm2pcm_sequencer.sv
// PDM clock generator and strobe sequencer for the PDM-to-PCM converter.
// Configuration is captured into shadow registers on START, so register
// writes while running have no effect until the next stop/start cycle.
// Every output is a flop. Strobes are computed one cycle ahead from the
// next-state counters so that each strobe is high in the cycle just before
// the PDM clock edge it accompanies.
module pdm2pcm_sequencer #(
   parameter int DIV_WIDTH = 7,
   parameter int DEC_WIDTH = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   pdm2pcm_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] hc_q, hc_d;
   logic [DEC_WIDTH-1:0] pc_q, pc_d;
   logic [DIV_WIDTH-1:0] div_s_q, div_s_d;
   logic [DEC_WIDTH-1:0] dec_s_q, dec_s_d;
   logic                 dual_s_q, dual_s_d;
   logic                 chan_s_q, chan_s_d;
   logic                 pdm_clk_q, pdm_clk_d;
   logic                 filter_clear_q, filter_clear_d;
   logic                 sample_left_q, sample_left_d;
   logic                 sample_right_q, sample_right_d;
   logic                 decimate_left_q, decimate_left_d;
   logic                 decimate_right_q, decimate_right_d;
   logic                 busy_q, busy_d;

   logic                 half_end;
   logic                 look;
   logic                 nxt_end;
   logic                 left_act;
   logic                 right_act;
   logic                 last_period;

   // Next-state, counter, shadow and one-cycle-ahead strobe computation
   always_comb begin
      state_d   = state_q;
      hc_d      = hc_q;
      pc_d      = pc_q;
      div_s_d   = div_s_q;
      dec_s_d   = dec_s_q;
      dual_s_d  = dual_s_q;
      chan_s_d  = chan_s_q;
      pdm_clk_d = pdm_clk_q;
      filter_clear_d = 1'b0;
      look      = 1'b0;
      half_end  = (hc_q == div_s_q);

      case (state_q)
         IDLE: begin
            pdm_clk_d = 1'b0;
            if (bus.interface_enable_i) begin
               state_d        = START;
               filter_clear_d = 1'b1;
            end
         end
         START: begin
            div_s_d   = bus.clock_divisor_i;
            dec_s_d   = bus.decimation_factor_i;
            dual_s_d  = bus.dual_channel_i;
            chan_s_d  = bus.channel_i;
            hc_d      = '0;
            pc_d      = '0;
            pdm_clk_d = 1'b0;
            state_d   = RUN;
            look      = 1'b1;
         end
         RUN: begin
            // Strobes for the next cycle are still decided here even when
            // enable has just dropped.
            look = 1'b1;
            if (half_end) begin
               hc_d      = '0;
               pdm_clk_d = ~pdm_clk_q;
               // A period ends with its high half; dec_s=0 wraps at 2^DEC_WIDTH
               // because dec_s-1 is then all ones.
               if (pdm_clk_q) begin
                  pc_d = (pc_q == dec_s_q - DEC_WIDTH'(1)) ? '0 : pc_q + DEC_WIDTH'(1);
               end
            end else begin
               hc_d = hc_q + DIV_WIDTH'(1);
            end
            if (!bus.interface_enable_i) begin
               state_d = STOP;
            end
         end
         STOP: begin
            // Finish a high half in progress so the mic never sees a runt pulse.
            if (!pdm_clk_q) begin
               state_d = IDLE;
            end else if (half_end) begin
               hc_d      = '0;
               pdm_clk_d = 1'b0;
               state_d   = IDLE;
            end else begin
               hc_d = hc_q + DIV_WIDTH'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            pdm_clk_d = 1'b0;
         end
      endcase

      nxt_end     = (hc_d == div_s_d);
      right_act   = dual_s_d | chan_s_d;
      left_act    = dual_s_d | ~chan_s_d;
      last_period = (pc_d == dec_s_d - DEC_WIDTH'(1));

      sample_right_d   = look & nxt_end & ~pdm_clk_d & right_act;
      sample_left_d    = look & nxt_end &  pdm_clk_d & left_act;
      decimate_right_d = sample_right_d & last_period;
      decimate_left_d  = sample_left_d & last_period;
      busy_d           = (state_d != IDLE);
   end

   // State, counters, shadows and registered outputs; async reset to idle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q          <= IDLE;
         hc_q             <= '0;
         pc_q             <= '0;
         div_s_q          <= '0;
         dec_s_q          <= '0;
         dual_s_q         <= 1'b0;
         chan_s_q         <= 1'b0;
         pdm_clk_q        <= 1'b0;
         filter_clear_q   <= 1'b0;
         sample_left_q    <= 1'b0;
         sample_right_q   <= 1'b0;
         decimate_left_q  <= 1'b0;
         decimate_right_q <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         hc_q             <= hc_d;
         pc_q             <= pc_d;
         div_s_q          <= div_s_d;
         dec_s_q          <= dec_s_d;
         dual_s_q         <= dual_s_d;
         chan_s_q         <= chan_s_d;
         pdm_clk_q        <= pdm_clk_d;
         filter_clear_q   <= filter_clear_d;
         sample_left_q    <= sample_left_d;
         sample_right_q   <= sample_right_d;
         decimate_left_q  <= decimate_left_d;
         decimate_right_q <= decimate_right_d;
         busy_q           <= busy_d;
      end
   end

   assign bus.pdm_clk_o        = pdm_clk_q;
   assign bus.filter_clear_o   = filter_clear_q;
   assign bus.sample_left_o    = sample_left_q;
   assign bus.sample_right_o   = sample_right_q;
   assign bus.decimate_left_o  = decimate_left_q;
   assign bus.decimate_right_o = decimate_right_q;
   assign bus.busy_o           = busy_q;

endmodule
